// File: rtl/muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_ctrl
// Description : Iterative RV32M multiply/divide sequencer for the Execute
//               stage. One operation per request: a shift-add multiplier or
//               a restoring divider, one iteration per cycle over WIDTH
//               cycles. The front of the pipeline is stalled while the
//               operation runs; the result is presented for a single cycle.
// Ports       :
//   clk        in   clock, rising edge
//   rst        in   synchronous reset, active low
//   MulDivE    in   instruction in E is an M-extension op (held while stalled)
//   MulDivOpE  in   funct3 (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU)
//   SrcAE      in   rs1 value
//   SrcBE      in   rs2 value
//   FlushE     in   E-stage flush, aborts the operation in flight
//   StallMD    out  stall for F, D and E pipeline registers
//   BusyMD     out  iterating
//   MDDoneE    out  result valid this cycle
//   MDResultE  out  result, zero unless MDDoneE is high
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             MulDivE,
    input  logic [2:0]       MulDivOpE,
    input  logic [WIDTH-1:0] SrcAE,
    input  logic [WIDTH-1:0] SrcBE,
    input  logic             FlushE,
    output logic             StallMD,
    output logic             BusyMD,
    output logic             MDDoneE,
    output logic [WIDTH-1:0] MDResultE
);

    localparam int               c_cw   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_cw-1:0]  c_last = c_cw'(WIDTH - 1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [c_cw-1:0]    r_cnt;
    logic [2:0]         r_op;
    logic [WIDTH-1:0]   r_mcand;      // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0] r_acc;        // {hi, lo} product or {rem, quo}
    logic               r_neg_res;
    logic               r_neg_rem;
    logic               r_done;
    logic [WIDTH-1:0]   r_result;

    // ------------------------------------------------------------------
    // Operand decode at acceptance
    // ------------------------------------------------------------------
    logic             w_is_div;
    logic             w_a_signed;
    logic             w_b_signed;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic             w_div0;
    logic             w_ovf;
    logic             w_accept;

    assign w_is_div   = MulDivOpE[2];
    // Multiply: A signed for MUL/MULH/MULHSU, B signed for MUL/MULH.
    // Divide: both signed for DIV/REM.
    assign w_a_signed = w_is_div ? ~MulDivOpE[0] : (MulDivOpE[1:0] != 2'b11);
    assign w_b_signed = w_is_div ? ~MulDivOpE[0] : ~MulDivOpE[1];
    assign w_a_neg    = w_a_signed & SrcAE[WIDTH-1];
    assign w_b_neg    = w_b_signed & SrcBE[WIDTH-1];
    assign w_abs_a    = w_a_neg ? (~SrcAE + 1'b1) : SrcAE;
    assign w_abs_b    = w_b_neg ? (~SrcBE + 1'b1) : SrcBE;
    assign w_div0     = w_is_div & (SrcBE == '0);
    assign w_ovf      = w_is_div & ~MulDivOpE[0]
                        & (SrcAE == {1'b1, {(WIDTH-1){1'b0}}})
                        & (SrcBE == {WIDTH{1'b1}});
    assign w_accept   = (r_state == c_st_idle) & MulDivE & ~FlushE;

    // ------------------------------------------------------------------
    // One iteration of the datapath
    // ------------------------------------------------------------------
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_diff;
    logic [2*WIDTH-1:0] w_div_next;
    logic [2*WIDTH-1:0] w_acc_next;

    // Shift-add: conditionally add into the high half, then shift the
    // whole accumulator right, carry included.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                        + (r_acc[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Restoring divide: the shifted remainder needs one extra bit so the
    // borrow of the trial subtraction is visible in the MSB.
    assign w_rem_sh   = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_diff     = w_rem_sh - {1'b0, r_mcand};
    assign w_div_next = w_diff[WIDTH]
                        ? {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                        : {w_diff[WIDTH-1:0],   r_acc[WIDTH-2:0], 1'b1};

    assign w_acc_next = r_op[2] ? w_div_next : w_mul_next;

    // ------------------------------------------------------------------
    // Result selection from the final accumulator value
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0] w_prod_c;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_final;

    assign w_prod_c = r_neg_res ? (~w_acc_next + 1'b1) : w_acc_next;
    assign w_quo    = r_neg_res ? (~w_acc_next[WIDTH-1:0] + 1'b1)
                                : w_acc_next[WIDTH-1:0];
    assign w_rem    = r_neg_rem ? (~w_acc_next[2*WIDTH-1:WIDTH] + 1'b1)
                                : w_acc_next[2*WIDTH-1:WIDTH];

    always_comb begin
        w_final = '0;
        case (r_op)
            3'b000:                 w_final = w_prod_c[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: w_final = w_prod_c[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         w_final = w_quo;
            default:                w_final = w_rem;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_next = c_st_idle;
        case (r_state)
            c_st_idle: begin
                if (w_accept) begin
                    w_state_next = (w_div0 | w_ovf) ? c_st_done : c_st_run;
                end
            end
            c_st_run: begin
                if (FlushE) begin
                    w_state_next = c_st_idle;
                end else if (r_cnt == c_last) begin
                    w_state_next = c_st_done;
                end else begin
                    w_state_next = c_st_run;
                end
            end
            default: w_state_next = c_st_idle;
        endcase
    end

    // FSM: outputs
    always_comb begin
        StallMD = 1'b0;
        BusyMD  = 1'b0;
        case (r_state)
            c_st_idle: StallMD = MulDivE & ~FlushE;
            c_st_run: begin
                StallMD = 1'b1;
                BusyMD  = 1'b1;
            end
            default: ;
        endcase
    end

    assign MDDoneE   = r_done;
    assign MDResultE = r_result;

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt     <= '0;
            r_op      <= '0;
            r_mcand   <= '0;
            r_acc     <= '0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_done    <= 1'b0;
            r_result  <= '0;
        end else begin
            // Done and result live for exactly the DONE cycle.
            r_done   <= 1'b0;
            r_result <= '0;
            if (w_accept) begin
                r_op      <= MulDivOpE;
                r_cnt     <= '0;
                r_neg_res <= w_a_neg ^ w_b_neg;
                r_neg_rem <= w_is_div & w_a_neg;
                r_mcand   <= w_is_div ? w_abs_b : w_abs_a;
                r_acc     <= {{WIDTH{1'b0}}, (w_is_div ? w_abs_a : w_abs_b)};
                if (w_div0) begin
                    r_done   <= 1'b1;
                    r_result <= MulDivOpE[1] ? SrcAE : {WIDTH{1'b1}};
                end else if (w_ovf) begin
                    r_done   <= 1'b1;
                    r_result <= MulDivOpE[1] ? {WIDTH{1'b0}}
                                             : {1'b1, {(WIDTH-1){1'b0}}};
                end
            end else if ((r_state == c_st_run) && !FlushE) begin
                r_acc <= w_acc_next;
                r_cnt <= r_cnt + 1'b1;
                if (r_cnt == c_last) begin
                    r_done   <= 1'b1;
                    r_result <= w_final;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_ctrl
// Description : Self-checking bench for muldiv_ctrl. Directed RV32M cases,
//               flush/reset aborts and randomized back-to-back operations
//               checked against an arithmetic reference of the M extension.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_ctrl;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         MulDivE;
    logic [2:0]   MulDivOpE;
    logic [W-1:0] SrcAE;
    logic [W-1:0] SrcBE;
    logic         FlushE;
    logic         StallMD;
    logic         BusyMD;
    logic         MDDoneE;
    logic [W-1:0] MDResultE;

    int ncmp = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    muldiv_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .MulDivE   (MulDivE),
        .MulDivOpE (MulDivOpE),
        .SrcAE     (SrcAE),
        .SrcBE     (SrcBE),
        .FlushE    (FlushE),
        .StallMD   (StallMD),
        .BusyMD    (BusyMD),
        .MDDoneE   (MDDoneE),
        .MDResultE (MDResultE)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // RV32M reference computed with wide integer arithmetic.
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      ua;
        longint      ub;
        logic [63:0] p;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'({32'b0, a});
        ub  = longint'({32'b0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = '0;
        case (op)
            3'd0: begin p = sa * sb; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf)    return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf)    return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Issue one op, follow it to its result and check timing and value.
    // Returns at the DONE cycle with MulDivE still asserted.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string tag);
        int          cyc;
        int          stalls;
        int          busy;
        int          exp_lat;
        logic        got;
        logic        stall_done;
        logic [31:0] res;
        cyc = 0; stalls = 0; busy = 0; got = 1'b0; stall_done = 1'b1; res = '0;
        exp_lat = (op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
                  ? 1 : W + 1;
        @(negedge clk);
        MulDivE = 1'b1; MulDivOpE = op; SrcAE = a; SrcBE = b;
        while (cyc < 3 * W) begin
            #2;
            if (MDDoneE) begin
                got = 1'b1; res = MDResultE; stall_done = StallMD;
                break;
            end
            if (StallMD) stalls++;
            if (BusyMD)  busy++;
            cyc++;
            @(negedge clk);
        end
        check({tag, " done seen"}, 32'(got), 32'd1);
        check({tag, " result"}, res, exp);
        check({tag, " latency"}, 32'(cyc), 32'(exp_lat));
        check({tag, " stall cycles"}, 32'(stalls), 32'(exp_lat));
        check({tag, " busy cycles"}, 32'(busy), 32'(exp_lat - 1));
        check({tag, " stall in done"}, 32'(stall_done), 32'd0);
    endtask

    // Drop the request after DONE and confirm the result pulse was single.
    task automatic release_op(input string tag);
        @(negedge clk);
        MulDivE = 1'b0;
        #2;
        check({tag, " done single pulse"}, 32'(MDDoneE), 32'd0);
        check({tag, " result cleared"}, MDResultE, 32'd0);
    endtask

    // Watch for a spurious completion after an abort.
    task automatic watch_quiet(input string tag);
        int pulses;
        pulses = 0;
        for (int k = 0; k < 2 * W; k++) begin
            @(negedge clk);
            #2;
            if (MDDoneE) pulses++;
        end
        check({tag, " no done pulse"}, 32'(pulses), 32'd0);
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          r;

        rst = 1'b0; MulDivE = 1'b0; MulDivOpE = '0; SrcAE = '0; SrcBE = '0; FlushE = 1'b0;

        // Reset and idle
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 2) rst = 1'b1;
            #2;
            check("reset stall", 32'(StallMD), 32'd0);
            check("reset busy",  32'(BusyMD),  32'd0);
            check("reset done",  32'(MDDoneE), 32'd0);
            check("reset result", MDResultE,   32'd0);
        end

        // Directed arithmetic
        run_op(3'd0, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFE, "MUL");
        release_op("MUL");
        run_op(3'd3, 32'hFFFF_FFFF, 32'h2, 32'h0000_0001, "MULHU");
        release_op("MULHU");
        run_op(3'd1, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, "MULH");
        run_op(3'd2, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, "MULHSU");
        run_op(3'd4, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, "DIV");
        run_op(3'd6, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, "REM");
        run_op(3'd5, 32'h0000_000A, 32'h3, 32'h0000_0003, "DIVU");
        release_op("DIVU");

        // Boundary cases
        run_op(3'd4, 32'h0000_000A, 32'h0, 32'hFFFF_FFFF, "DIV by zero");
        release_op("DIV by zero");
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, "REM overflow");
        release_op("REM overflow");

        // Flush at RUN cycle 10
        @(negedge clk);
        MulDivE = 1'b1; MulDivOpE = 3'd0; SrcAE = 32'd3; SrcBE = 32'd5;
        for (int k = 0; k < 11; k++) @(negedge clk);
        FlushE = 1'b1;
        #2;
        check("flush busy in run", 32'(BusyMD), 32'd1);
        check("flush stall in run", 32'(StallMD), 32'd1);
        @(negedge clk);
        FlushE = 1'b0; MulDivE = 1'b0;
        #2;
        check("flush stall after", 32'(StallMD), 32'd0);
        check("flush busy after",  32'(BusyMD),  32'd0);
        watch_quiet("flush");

        // Reset at RUN cycle 5
        @(negedge clk);
        MulDivE = 1'b1; MulDivOpE = 3'd0; SrcAE = 32'd3; SrcBE = 32'd5;
        for (int k = 0; k < 6; k++) @(negedge clk);
        rst = 1'b0; MulDivE = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #2;
        check("reset-abort stall after", 32'(StallMD), 32'd0);
        check("reset-abort busy after",  32'(BusyMD),  32'd0);
        watch_quiet("reset-abort");

        run_op(3'd0, 32'd3, 32'd5, 32'h0000_000F, "MUL 3x5 after aborts");
        release_op("MUL 3x5 after aborts");

        // Randomized back-to-back operations
        for (int n = 0; n < 30; n++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            r  = int'($urandom_range(0, 9));
            if (r == 0) b = 32'h0;
            if (r == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            if (r == 2) b = 32'($urandom_range(1, 15));
            if (r == 3) a = 32'($urandom_range(0, 100));
            run_op(op, a, b, model(op, a, b), $sformatf("rand%0d op%0d", n, op));
        end
        release_op("rand tail");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
`default_nettype wire
